// File: rtl/fwd_hazard_unit_if.sv
// Decode/producer/EX-select bundle shared between the pipeline and the forwarding unit.
// The pipeline side is the master; the forwarding unit is the slave.
interface fwd_hazard_unit_if #(
  parameter int RN_W  = 5,
  parameter int NPORT = 2,
  parameter int NSTG  = 2,
  parameter int CNT_W = 16
);
  localparam int SEL_W = $clog2(NSTG + 1);

  logic                    hold;
  logic                    flush;
  logic [NPORT*RN_W-1:0]   dec_rn;
  logic [NPORT-1:0]        dec_rd;
  logic [NSTG*RN_W-1:0]    p_rn;
  logic [NSTG-1:0]         p_we;
  logic [NSTG-1:0]         p_ld;
  logic [NPORT*SEL_W-1:0]  ex_sel;
  logic                    stall;
  logic [CNT_W-1:0]        stall_cnt;

  modport master (
    output hold, flush, dec_rn, dec_rd, p_rn, p_we, p_ld,
    input  ex_sel, stall, stall_cnt
  );

  modport slave (
    input  hold, flush, dec_rn, dec_rd, p_rn, p_we, p_ld,
    output ex_sel, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select register and load-use interlock for the mips789 pipeline.
// Nearest matching producer wins; a load too close to EX stalls decode instead.
module fwd_hazard_unit #(
  parameter int RN_W   = 5,
  parameter int NPORT  = 2,
  parameter int NSTG   = 2,
  parameter int LD_LAT = 1,
  parameter int CNT_W  = 16,
  localparam int SEL_W = $clog2(NSTG + 1)
) (
  input  logic                clk,
  input  logic                rst,
  fwd_hazard_unit_if.slave    bus
);

  logic [NPORT*SEL_W-1:0] sel_nxt;
  logic [NPORT*SEL_W-1:0] ex_sel_d;
  logic [NPORT*SEL_W-1:0] ex_sel_q;
  logic [CNT_W-1:0]       stall_cnt_d;
  logic [CNT_W-1:0]       stall_cnt_q;
  logic                   stall;
  logic                   hit;

  // Only the winning (nearest) match per port is inspected for a load hazard.
  always_comb begin
    sel_nxt = '0;
    stall   = 1'b0;
    hit     = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      hit = 1'b0;
      for (int p = 0; p < NSTG; p++) begin
        if (!hit && bus.dec_rd[i] && bus.p_we[p] &&
            (bus.dec_rn[i*RN_W +: RN_W] != '0) &&
            (bus.p_rn[p*RN_W +: RN_W] == bus.dec_rn[i*RN_W +: RN_W])) begin
          hit                        = 1'b1;
          sel_nxt[i*SEL_W +: SEL_W]  = SEL_W'(p + 1);
          if (bus.p_ld[p] && (p < LD_LAT)) begin
            stall = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    ex_sel_d    = sel_nxt;
    stall_cnt_d = stall_cnt_q;
    if (bus.hold) begin
      ex_sel_d = ex_sel_q;
    end else begin
      if (bus.flush || stall) begin
        ex_sel_d = '0;
      end
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_sel_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_sel_q    <= ex_sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.ex_sel    = ex_sel_q;
  assign bus.stall     = stall;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: default geometry (2 ports, 2 positions, LD_LAT=1)
// with a 4-bit stall counter so saturation is reachable quickly.
module tb_fwd_hazard_unit;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  fwd_hazard_unit_if #(.RN_W(5), .NPORT(2), .NSTG(2), .CNT_W(4)) bus ();

  fwd_hazard_unit #(
    .RN_W(5), .NPORT(2), .NSTG(2), .LD_LAT(1), .CNT_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic h, input logic f,
                               input logic [4:0] rn0, input logic [4:0] rn1,
                               input logic [1:0] rd,
                               input logic [4:0] prn0, input logic [4:0] prn1,
                               input logic [1:0] we, input logic [1:0] ld);
    bus.hold   = h;
    bus.flush  = f;
    bus.dec_rn = {rn1, rn0};
    bus.dec_rd = rd;
    bus.p_rn   = {prn1, prn0};
    bus.p_we   = we;
    bus.p_ld   = ld;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      $error("[TB] miscompare on %s", tag);
    end
  endtask

  function automatic logic [31:0] sel0();
    return {30'd0, bus.ex_sel[1:0]};
  endfunction

  function automatic logic [31:0] sel1();
    return {30'd0, bus.ex_sel[3:2]};
  endfunction

  function automatic logic [31:0] cnt();
    return {28'd0, bus.stall_cnt};
  endfunction

  function automatic logic [31:0] stl();
    return {31'd0, bus.stall};
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset with a live load-use hazard on the inputs.
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd9, 5'd3, 2'b11, 5'd9, 5'd3, 2'b11, 2'b01);
    checkOutput("stall_in_reset", stl(), 32'd1);
    tick();
    checkOutput("rst_sel0", sel0(), 32'd0);
    checkOutput("rst_sel1", sel1(), 32'd0);
    checkOutput("rst_cnt", cnt(), 32'd0);
    tick();
    checkOutput("rst_cnt2", cnt(), 32'd0);
    rst = 1'b1;

    // Back-to-back ALU forward from EX.
    applyStimulus(1'b0, 1'b0, 5'd5, 5'd0, 2'b01, 5'd5, 5'd0, 2'b01, 2'b00);
    checkOutput("alu_stall", stl(), 32'd0);
    tick();
    checkOutput("alu_sel0", sel0(), 32'd1);
    checkOutput("alu_sel1", sel1(), 32'd0);
    checkOutput("alu_cnt", cnt(), 32'd0);

    // Nearest producer wins when both positions write the same register.
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd7, 2'b10, 5'd7, 5'd7, 2'b11, 2'b00);
    tick();
    checkOutput("prio_sel1", sel1(), 32'd1);
    checkOutput("prio_sel0", sel0(), 32'd0);

    // Only the farther position matches.
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd7, 2'b10, 5'd7, 5'd7, 2'b10, 2'b00);
    tick();
    checkOutput("far_sel1", sel1(), 32'd2);

    // r0 never matches, even from a load.
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 2'b11, 2'b11);
    checkOutput("r0_stall", stl(), 32'd0);
    tick();
    checkOutput("r0_sel0", sel0(), 32'd0);
    checkOutput("r0_sel1", sel1(), 32'd0);
    checkOutput("r0_cnt", cnt(), 32'd0);

    // Load-use: one stall cycle, then forward from position 1.
    applyStimulus(1'b0, 1'b0, 5'd9, 5'd0, 2'b01, 5'd9, 5'd0, 2'b01, 2'b01);
    checkOutput("ld_stall", stl(), 32'd1);
    tick();
    checkOutput("ld_sel0", sel0(), 32'd0);
    checkOutput("ld_cnt", cnt(), 32'd1);
    applyStimulus(1'b0, 1'b0, 5'd9, 5'd0, 2'b01, 5'd0, 5'd9, 2'b10, 2'b10);
    checkOutput("ld_shift_stall", stl(), 32'd0);
    tick();
    checkOutput("ld_shift_sel0", sel0(), 32'd2);
    checkOutput("ld_shift_cnt", cnt(), 32'd1);

    // Hold freezes select and counter while stall stays visible.
    applyStimulus(1'b0, 1'b0, 5'd5, 5'd0, 2'b01, 5'd5, 5'd0, 2'b01, 2'b00);
    tick();
    checkOutput("hold_pre_sel0", sel0(), 32'd1);
    applyStimulus(1'b1, 1'b0, 5'd9, 5'd0, 2'b01, 5'd9, 5'd0, 2'b01, 2'b01);
    for (int k = 0; k < 3; k++) begin
      checkOutput("hold_stall", stl(), 32'd1);
      tick();
      checkOutput("hold_sel0", sel0(), 32'd1);
      checkOutput("hold_cnt", cnt(), 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 5'd9, 5'd0, 2'b01, 5'd9, 5'd0, 2'b01, 2'b01);
    tick();
    checkOutput("unhold_sel0", sel0(), 32'd0);
    checkOutput("unhold_cnt", cnt(), 32'd2);

    // Flush alone clears the select and leaves the counter alone.
    applyStimulus(1'b0, 1'b1, 5'd5, 5'd0, 2'b01, 5'd5, 5'd0, 2'b01, 2'b00);
    tick();
    checkOutput("flush_sel0", sel0(), 32'd0);
    checkOutput("flush_cnt", cnt(), 32'd2);

    // Flush together with stall: only the stall counts.
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd9, 2'b10, 5'd9, 5'd0, 2'b01, 2'b01);
    checkOutput("flst_stall", stl(), 32'd1);
    tick();
    checkOutput("flst_sel1", sel1(), 32'd0);
    checkOutput("flst_cnt", cnt(), 32'd3);

    // Reset mid-stall wins over the counter update.
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd9, 5'd0, 2'b01, 5'd9, 5'd0, 2'b01, 2'b01);
    tick();
    checkOutput("midrst_cnt", cnt(), 32'd0);
    checkOutput("midrst_sel0", sel0(), 32'd0);
    rst = 1'b1;

    // Saturation of the 4-bit counter under a persistent stall.
    for (int k = 1; k <= 20; k++) begin
      tick();
      checkOutput("sat_cnt", cnt(), (k < 15) ? k : 15);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
